// File: rtl/misr_pkg.sv
// Shared types and elaboration helpers for the MISR signature compactor.
package misr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} misr_state_e;

    localparam logic [11:0] MISR_POLY_12 = 12'h053;

    // Stage 0 must always receive feedback, and the response bits must fit the register.
    function automatic bit misr_cfg_ok(int unsigned width, int unsigned n_in, bit poly_lsb);
        return poly_lsb && (width >= 4) && (n_in >= 1) && (n_in <= width);
    endfunction

endpackage

// File: rtl/misr_core.sv
// WIDTH-bit MISR register: Galois-style feedback from the top stage with response bits
// XORed into the low stages.
module misr_core
    import misr_pkg::*;
#(
    parameter int unsigned       WIDTH = 12,
    parameter int unsigned       N_IN  = 3,
    parameter logic [WIDTH-1:0]  POLY  = MISR_POLY_12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic [N_IN-1:0]  din,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] upd;

    always_comb begin
        upd = {sig_q[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{sig_q[WIDTH-1]}});
        upd[N_IN-1:0] = upd[N_IN-1:0] ^ din;
    end

    // Value the register takes after this cycle, ignoring a load.
    assign sig_next = step ? upd : sig_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sig_q <= '0;
        end else if (load) begin
            sig_q <= load_val;
        end else if (step) begin
            sig_q <= upd;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/misr_compactor.sv
// MISR compactor with start/run/done control, saturating cycle counter and a registered
// golden-signature verdict.
module misr_compactor
    import misr_pkg::*;
#(
    parameter int unsigned       WIDTH  = 12,
    parameter int unsigned       N_IN   = 3,
    parameter logic [WIDTH-1:0]  POLY   = MISR_POLY_12,
    parameter logic [WIDTH-1:0]  SEED   = '0,
    parameter logic [WIDTH-1:0]  GOLDEN = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             din_valid,
    input  logic [N_IN-1:0]  din,
    input  logic             bist_end,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] cycle_cnt
);

    if (!misr_cfg_ok(WIDTH, N_IN, POLY[0])) begin : g_bad_cfg
        $error("misr_compactor: illegal WIDTH/N_IN/POLY combination");
    end

    misr_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q, pass_q;
    logic             step;
    logic [WIDTH-1:0] sig_next;

    // start reloads from any state; it also pre-empts a step in RUN.
    assign step = (state_q == RUN) && din_valid && !start;

    misr_core #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .POLY  (POLY)
    ) u_core (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (start),
        .load_val (SEED),
        .step     (step),
        .din      (din),
        .sig      (sig),
        .sig_next (sig_next)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        cnt_q <= '0;
                    end else begin
                        if (din_valid && (cnt_q != '1)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (bist_end) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (sig_next == GOLDEN);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_misr_compactor.sv
// Randomised bench for misr_compactor against a behavioural signature/sequence model.
module tb_misr_compactor;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        din_valid = 1'b0;
    logic [2:0]  din = 3'b000;
    logic        bist_end = 1'b0;

    logic [11:0] sig_a, sig_b, sig_c;
    logic        busy_a, done_a, pass_a;
    logic        busy_b, done_b, pass_b;
    logic        busy_c, done_c, pass_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int total = 0;
    int bad = 0;

    // Model state: 0 idle, 1 run, 2 done.
    int          m_st = 0;
    logic [11:0] m_sig = '0;
    int          m_cnt = 0;

    always #5 CLK = ~CLK;

    misr_compactor #(.GOLDEN(12'h0A1)) u_a (
        .CLK(CLK), .RST_N(RST_N), .start(start), .din_valid(din_valid), .din(din),
        .bist_end(bist_end), .sig(sig_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .cycle_cnt(cnt_a)
    );

    misr_compactor #(.GOLDEN(12'h0A3)) u_b (
        .CLK(CLK), .RST_N(RST_N), .start(start), .din_valid(din_valid), .din(din),
        .bist_end(bist_end), .sig(sig_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .cycle_cnt(cnt_b)
    );

    misr_compactor #(.GOLDEN(12'h0A1), .CNT_W(2)) u_c (
        .CLK(CLK), .RST_N(RST_N), .start(start), .din_valid(din_valid), .din(din),
        .bist_end(bist_end), .sig(sig_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .cycle_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Polynomial arithmetic: multiply by x modulo the feedback polynomial, then add the response.
    function automatic logic [11:0] model_step(input logic [11:0] s, input logic [2:0] d);
        int v;
        v = int'(s) * 2;
        if (v >= 4096) v = (v - 4096) ^ 'h053;
        return 12'(v) ^ {9'b0, d};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_update();
        if (!RST_N) begin
            m_st = 0; m_sig = '0; m_cnt = 0;
        end else if (start) begin
            m_st = 1; m_sig = 12'h000; m_cnt = 0;
        end else if (m_st == 1) begin
            if (din_valid) begin
                m_sig = model_step(m_sig, din);
                m_cnt++;
            end
            if (bist_end) m_st = 2;
        end
    endtask

    task automatic check_all();
        logic ex_done;
        ex_done = (m_st == 2);
        check("sig_a",  32'(sig_a), 32'(m_sig));
        check("sig_c",  32'(sig_c), 32'(m_sig));
        check("cnt16",  32'(cnt_a), 32'(sat(m_cnt, 65535)));
        check("cnt2",   32'(cnt_c), 32'(sat(m_cnt, 3)));
        check("busy",   32'(busy_a), 32'(m_st == 1));
        check("done",   32'(done_a), 32'(ex_done));
        check("pass_a", 32'(pass_a), 32'(ex_done && (m_sig == 12'h0A1)));
        check("pass_b", 32'(pass_b), 32'(ex_done && (m_sig == 12'h0A3)));
        check("busy_b", 32'(busy_b), 32'(busy_a));
        check("done_c", 32'(done_c), 32'(ex_done));
    endtask

    task automatic cyc(input logic rst, input logic st, input logic v, input logic [2:0] d,
                       input logic be);
        RST_N = rst; start = st; din_valid = v; din = d; bist_end = be;
        @(posedge CLK);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        @(negedge CLK);
        cyc(0, 0, 0, 3'b000, 0);
        cyc(0, 1, 1, 3'b111, 1);
        check("rst_sig", 32'(sig_a), 32'h0);
        // Directed walk through the reference sequence.
        cyc(1, 1, 0, 3'b000, 0);
        cyc(1, 0, 1, 3'b001, 0);
        check("first_sig", 32'(sig_a), 32'h001);
        check("first_cnt", 32'(cnt_a), 32'd1);
        for (int i = 0; i < 11; i++) cyc(1, 0, 1, 3'b000, 0);
        check("sig_800", 32'(sig_a), 32'h800);
        cyc(1, 0, 1, 3'b000, 0);
        check("sig_fb", 32'(sig_a), 32'h053);
        cyc(1, 0, 1, 3'b111, 1);
        check("final_sig", 32'(sig_a), 32'h0A1);
        check("pass_match", 32'(pass_a), 32'd1);
        check("pass_offby1", 32'(pass_b), 32'd0);
        check("cnt_sat2", 32'(cnt_c), 32'd3);
        cyc(1, 0, 1, 3'b101, 1);   // ignored in DONE
        // Restart, idle valid for 5 cycles, then finish.
        cyc(1, 1, 0, 3'b000, 0);
        cyc(1, 0, 1, 3'b011, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 3'b111, 0);
        cyc(1, 0, 0, 3'b000, 1);
        // Mid-RUN restart beats bist_end.
        cyc(1, 1, 0, 3'b000, 0);
        cyc(1, 0, 1, 3'b110, 0);
        cyc(1, 1, 1, 3'b110, 1);
        check("restart_sig", 32'(sig_a), 32'h000);
        check("restart_done", 32'(done_a), 32'd0);
        // Reset in RUN, then in DONE.
        cyc(1, 0, 1, 3'b010, 0);
        cyc(0, 0, 1, 3'b010, 0);
        cyc(1, 1, 0, 3'b000, 0);
        cyc(1, 0, 1, 3'b111, 1);
        cyc(0, 0, 0, 3'b000, 0);
        check("rst_done", 32'(done_a), 32'd0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 9) < 7), 3'($urandom), ($urandom_range(0, 39) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
